// File: rtl/beat_lane_if.sv
// Chart-reader handshake plus row position/mask bundle for beat_lane_sequencer.
// Carries underrun_count only when UNDERRUN_COUNT_EN is defined.
interface beat_lane_if;
  logic       chart_valid;
  logic [3:0] chart_notes;
  logic       chart_ready;
  logic [9:0] beat_pos1, beat_pos2, beat_pos3, beat_pos4;
  logic [3:0] beat_notes1, beat_notes2, beat_notes3, beat_notes4;
  logic       frame_tick;
  logic       underrun;
`ifdef UNDERRUN_COUNT_EN
  logic [7:0] underrun_count;
`endif

  // Chart reader / renderer side
  modport master (
    output chart_valid, chart_notes,
    input  chart_ready,
    input  beat_pos1, beat_pos2, beat_pos3, beat_pos4,
    input  beat_notes1, beat_notes2, beat_notes3, beat_notes4,
    input  frame_tick, underrun
`ifdef UNDERRUN_COUNT_EN
    , input underrun_count
`endif
  );

  // Sequencer side
  modport slave (
    input  chart_valid, chart_notes,
    output chart_ready,
    output beat_pos1, beat_pos2, beat_pos3, beat_pos4,
    output beat_notes1, beat_notes2, beat_notes3, beat_notes4,
    output frame_tick, underrun
`ifdef UNDERRUN_COUNT_EN
    , output underrun_count
`endif
  );
endinterface

// File: rtl/beat_lane_sequencer.sv
// Four beat rows advancing once per frame with per-row mask refill from the chart reader.
// Optional UNDERRUN_COUNT_EN adds a saturating 8-bit underrun event counter.
module beat_lane_sequencer #(
  parameter int unsigned PIXELSPEED = 3,
  parameter int unsigned WRAP_POS   = 639,
  parameter int unsigned SPACING    = 160
) (
  input  logic        vgaclk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        run,
  beat_lane_if.slave  bus
);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_PAUSE} state_t;

  state_t     state;
  logic       vsync_q;
  logic       frame_tick;
  logic       underrun;
  logic [3:0] pending;
  logic [1:0] fill_idx;
  logic [9:0] pos   [4];
  logic [3:0] notes [4];

  logic       chart_ready;
  logic       xfer;
  logic       advance;
  logic [1:0] load_idx;
  logic [3:0] load_row;
  logic [3:0] starve;

  // pending is only ever set while running, so it is all-zero in S_FILL
  assign chart_ready = (state == S_FILL) || (pending != 4'd0);
  assign xfer        = bus.chart_valid && chart_ready;
  assign advance     = frame_tick && (state == S_RUN);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    load_idx = fill_idx;
    if (state != S_FILL) begin
      load_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
        if (pending[i]) load_idx = 2'(i);
      end
    end
    load_row = 4'd0;
    if (xfer) load_row[load_idx] = 1'b1;
    // A row still waiting at a tick misses its pass unless it is being loaded right now
    starve = advance ? (pending & ~load_row) : 4'd0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
      pending    <= 4'd0;
      fill_idx   <= 2'd0;
      // NOTE: these small register arrays are flops, not RAM, so they are reset like any other state.
      for (int k = 0; k < 4; k++) begin
        pos[k]   <= 10'(k * SPACING);
        notes[k] <= 4'd0;
      end
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync_q & ~vsync;
      if (starve != 4'd0) underrun <= 1'b1;

      for (int k = 0; k < 4; k++) begin
        if (load_row[k]) begin
          notes[k]   <= bus.chart_notes;
          pending[k] <= 1'b0;
        end
        if (advance) begin
          if (pos[k] >= 10'(WRAP_POS)) begin
            pos[k]     <= 10'd0;
            notes[k]   <= 4'd0;
            pending[k] <= 1'b1;
          end else begin
            pos[k] <= pos[k] + 10'(PIXELSPEED);
          end
        end
        if (starve[k]) pending[k] <= 1'b0;
      end

      case (state)
        S_FILL: begin
          if (xfer) begin
            fill_idx <= fill_idx + 2'd1;
            if (fill_idx == 2'd3) state <= run ? S_RUN : S_PAUSE;
          end
        end
        S_RUN:   if (!run) state <= S_PAUSE;
        S_PAUSE: if (run)  state <= S_RUN;
        default: state <= S_FILL;
      endcase
    end
  end

`ifdef UNDERRUN_COUNT_EN
  logic [7:0] underrun_count;
  logic [8:0] count_sum;

  assign count_sum = {1'b0, underrun_count} + 9'($countones(starve));

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n)                underrun_count <= 8'd0;
    else if (count_sum[8])     underrun_count <= 8'hFF;
    else                       underrun_count <= count_sum[7:0];
  end

  assign bus.underrun_count = underrun_count;
`endif

  assign bus.chart_ready = chart_ready;
  assign bus.frame_tick  = frame_tick;
  assign bus.underrun    = underrun;
  assign bus.beat_pos1   = pos[0];
  assign bus.beat_pos2   = pos[1];
  assign bus.beat_pos3   = pos[2];
  assign bus.beat_pos4   = pos[3];
  assign bus.beat_notes1 = notes[0];
  assign bus.beat_notes2 = notes[1];
  assign bus.beat_notes3 = notes[2];
  assign bus.beat_notes4 = notes[3];

endmodule

// File: tb/tb_beat_lane_sequencer.sv
// Scoreboard bench for beat_lane_sequencer: a behavioural row model queues expected
// values at each stimulus, and they are popped and compared once the DUT has reacted.
module tb_beat_lane_sequencer;

  logic vgaclk = 1'b0;
  logic rst_n  = 1'b0;
  logic vsync  = 1'b1;
  logic run    = 1'b0;

  beat_lane_if bus ();

  beat_lane_sequencer dut (
    .vgaclk (vgaclk),
    .rst_n  (rst_n),
    .vsync  (vsync),
    .run    (run),
    .bus    (bus)
  );

  always #5 vgaclk = ~vgaclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         pos_m     [4];
  logic [3:0] notes_m   [4];
  bit         pending_m [4];
  bit         underrun_m;
  int         count_m;
  bit         filling_m;
  int         fill_m;
  bit         run_m;

  function automatic bit any_pending();
    return pending_m[0] | pending_m[1] | pending_m[2] | pending_m[3];
  endfunction

  function automatic bit ready_m();
    return filling_m || any_pending();
  endfunction

  function automatic int lowest_pending();
    for (int k = 0; k < 4; k++) if (pending_m[k]) return k;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      pos_m[k]     = 160 * k;
      notes_m[k]   = 4'd0;
      pending_m[k] = 1'b0;
    end
    underrun_m = 1'b0;
    count_m    = 0;
    filling_m  = 1'b1;
    fill_m     = 0;
  endfunction

  function automatic void model_tick();
    for (int k = 0; k < 4; k++) begin
      if (pending_m[k]) begin
        underrun_m   = 1'b1;
        pending_m[k] = 1'b0;
        if (count_m < 255) count_m++;
      end
      if (pos_m[k] >= 639) begin
        pos_m[k]     = 0;
        notes_m[k]   = 4'd0;
        pending_m[k] = 1'b1;
      end else begin
        pos_m[k] = pos_m[k] + 3;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef enum {K_POS, K_NOTES, K_READY, K_UNDERRUN, K_COUNT} kind_t;
  typedef struct {
    kind_t       kind;
    int          row;
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb_q[$];

  function automatic logic [31:0] actual(kind_t kind, int row);
    case (kind)
      K_POS: case (row)
        0: return 32'(bus.beat_pos1);
        1: return 32'(bus.beat_pos2);
        2: return 32'(bus.beat_pos3);
        default: return 32'(bus.beat_pos4);
      endcase
      K_NOTES: case (row)
        0: return 32'(bus.beat_notes1);
        1: return 32'(bus.beat_notes2);
        2: return 32'(bus.beat_notes3);
        default: return 32'(bus.beat_notes4);
      endcase
      K_READY:    return 32'(bus.chart_ready);
      K_UNDERRUN: return 32'(bus.underrun);
`ifdef UNDERRUN_COUNT_EN
      K_COUNT:    return 32'(bus.underrun_count);
`endif
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void expect_item(kind_t kind, int row, logic [31:0] exp, string tag);
    sb_t e;
    e.kind = kind;
    e.row  = row;
    e.exp  = exp;
    e.tag  = $sformatf("%s.%s%0d", tag, kind.name(), row + 1);
    sb_q.push_back(e);
  endfunction

  function automatic void expect_state(string tag);
    for (int k = 0; k < 4; k++) begin
      expect_item(K_POS,   k, 32'(pos_m[k]),   tag);
      expect_item(K_NOTES, k, 32'(notes_m[k]), tag);
    end
    expect_item(K_READY,    0, 32'(ready_m()),    tag);
    expect_item(K_UNDERRUN, 0, 32'(underrun_m),   tag);
`ifdef UNDERRUN_COUNT_EN
    expect_item(K_COUNT,    0, 32'(count_m),      tag);
`endif
  endfunction

  task automatic drain();
    sb_t e;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(e.tag, actual(e.kind, e.row), e.exp);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    step();
    expect_state(tag);
    drain();
    rst_n = 1'b1;
    step();
  endtask

  // One vsync pulse; counts frame_tick cycles and compares the row state afterwards
  task automatic tick(input string tag);
    int ft = 0;
    if (run_m && !filling_m) model_tick();
    expect_state(tag);
    vsync = 1'b0;
    repeat (3) begin
      step();
      if (bus.frame_tick) ft++;
    end
    vsync = 1'b1;
    repeat (2) begin
      step();
      if (bus.frame_tick) ft++;
    end
    check({tag, ".frame_tick_cycles"}, 32'(ft), 32'd1);
    drain();
  endtask

  task automatic xfer(input logic [3:0] pattern, input string tag);
    int row;
    int waited = 0;
    bus.chart_valid = 1'b1;
    bus.chart_notes = pattern;
    while (!bus.chart_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!bus.chart_ready) begin
      check({tag, ".ready_timeout"}, 32'(bus.chart_ready), 32'd1);
      bus.chart_valid = 1'b0;
      return;
    end
    if (filling_m) begin
      row = fill_m;
      fill_m++;
      if (fill_m == 4) filling_m = 1'b0;
    end else begin
      row = lowest_pending();
      if (row < 0) row = 0;
      pending_m[row] = 1'b0;
    end
    notes_m[row] = pattern;
    expect_item(K_NOTES, row, 32'(pattern),   tag);
    expect_item(K_READY, 0,   32'(ready_m()), tag);
    step();
    bus.chart_valid = 1'b0;
    drain();
  endtask

  // Refill pending rows in index order, stopping at the first starved one
  task automatic refill(input logic [3:0] starve_mask);
    int r;
    int guard = 0;
    r = lowest_pending();
    while (r >= 0 && !starve_mask[r] && guard < 8) begin
      xfer(4'($urandom_range(1, 15)), "refill");
      r = lowest_pending();
      guard++;
    end
  endtask

  initial begin
    int guard;
    bus.chart_valid = 1'b0;
    bus.chart_notes = 4'd0;
    run_m = 1'b0;

    do_reset("reset");

    // Filling: ticks pulse but rows stay put
    repeat (3) tick("fill_tick");

    run   = 1'b1;
    run_m = 1'b1;
    step();
    xfer(4'b1001, "fill1");
    xfer(4'b0010, "fill2");
    xfer(4'b0100, "fill3");
    xfer(4'b0011, "fill4");
    expect_state("loaded");
    drain();

    tick("first_tick");
    check("first_tick.pos4_direct", 32'(bus.beat_pos4), 32'd483);

    guard = 0;
    while (pos_m[3] != 639 && guard < 400) begin
      tick("adv");
      refill(4'b0000);
      guard++;
    end
    check("pos4_at_wrap_pos", 32'(bus.beat_pos4), 32'd639);

    tick("wrap4");
    check("wrap4.ready_direct", 32'(bus.chart_ready), 32'd1);
    xfer(4'b1111, "refill4");
    check("refill4.notes4_direct", 32'(bus.beat_notes4), 32'd15);

    // Row 4 is starved on its next wrap
    guard = 0;
    while (!pending_m[3] && guard < 400) begin
      tick("adv2");
      refill(4'b1000);
      guard++;
    end
    refill(4'b1000);
    tick("underrun");
    check("underrun.flag_direct", 32'(bus.underrun), 32'd1);
    check("underrun.notes4_blank", 32'(bus.beat_notes4), 32'd0);
`ifdef UNDERRUN_COUNT_EN
    check("underrun.count_direct", 32'(bus.underrun_count), 32'd1);
`endif

    // Find a wrap, then pause with the refill still owed
    guard = 0;
    while (!any_pending() && guard < 400) begin
      tick("seek");
      guard++;
    end
    run   = 1'b0;
    run_m = 1'b0;
    step();
    repeat (5) tick("pause");
    refill(4'b0000);
    run   = 1'b1;
    run_m = 1'b1;
    step();
    tick("resume");

    // Asynchronous reset with a refill outstanding drops it
    guard = 0;
    while (!any_pending() && guard < 400) begin
      tick("seek2");
      guard++;
    end
    bus.chart_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_state("mid_reset");
    drain();
    step();
    rst_n = 1'b1;
    step();
    expect_state("after_mid_reset");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/beat_lane_sequencer.md
Name: beat_lane_sequencer

Overview:
- Upstream feeder for the note-highway VGA renderer.
- Owns the four beat-row positions and their 4-bit column masks (col1..col4).
- Advances the rows once per frame, on the vsync edge synchronised into the pixel clock domain.
- Refills each row's mask from the chart reader over a valid/ready handshake whenever that row wraps back to the top.

Parameters:
PIXELSPEED, 3, pixels each row advances per frame tick
WRAP_POS, 639, position at or above which a row wraps to 0; WRAP_POS+PIXELSPEED must be < 1024
SPACING, 160, initial offset between rows: row k starts at k*SPACING, k=0..3

Ports:
vgaclk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
vsync  in  1  vsync from VGA timing generator, active low, vgaclk domain
run  in  1  1 = rows advance on frame tick; 0 = freeze
chart_valid  in  1  chart reader has a pattern
chart_notes  in  4  pattern; bit i = note in column i+1
chart_ready  out  1  sequencer accepts pattern this cycle
beat_pos1..beat_pos4  out  10 each  row positions to renderer
beat_notes1..beat_notes4  out  4 each  row masks to renderer
frame_tick  out  1  one-cycle pulse per frame
underrun  out  1  sticky: a row missed its refill

Behaviour:
- Reset (async, rst_n=0):
  - beat_posK = (K-1)*SPACING (0/160/320/480); all beat_notes = 0.
  - pending = 0; fill_idx = 0; underrun = 0; frame_tick = 0; state = S_FILL; vsync_q = 1.
- Frame tick:
  - vsync_q registers vsync.
  - frame_tick = vsync_q & ~vsync, registered: pulses the cycle after vsync first reads low.
  - Exactly one pulse per vsync assertion.
- Handshake:
  - Transfer occurs when chart_valid & chart_ready on a rising edge.
  - chart_ready is decoded from registered state only: 1 in S_FILL, or in S_RUN/S_PAUSE when pending != 0. It never depends on chart_valid.
- FSM:
  - S_FILL:
    - Transfers load beat_notes(fill_idx+1); fill_idx increments.
    - After the 4th transfer, go to S_RUN if run=1, else S_PAUSE.
    - Frame ticks are ignored; positions hold.
  - S_RUN:
    - run=0 -> S_PAUSE.
    - On frame_tick each row updates: if pos >= WRAP_POS then pos <= 0, notes <= 0, pending[k] <= 1; else pos <= pos+PIXELSPEED.
  - S_PAUSE:
    - run=1 -> S_RUN.
    - Frame ticks are ignored; positions frozen.
    - Refill transfers still complete.
- Refill:
  - A transfer loads the lowest-index row with pending set and clears that pending bit.
  - Loaded mask is visible on beat_notesK the next cycle.
- Underrun:
  - Applies on an advancing frame_tick (S_RUN) while pending[k] is still set and row k is not being loaded that cycle.
  - Effect: underrun <= 1 (sticky until reset), pending[k] <= 0.
  - Row k stays blank (notes 0) for that pass; a late pattern is not accepted for that row.
- Simultaneous events:
  - Refill of row k in the same cycle as a tick: the load wins and no underrun is flagged for row k; row k's position still advances.
  - Wrap of row j in the same cycle as refill of row k (j != k): both apply.
  - Several rows wrapping on one tick: each sets its own pending bit; refills then go in index order.
- Width: 10-bit unsigned positions; no overflow is possible under the parameter constraint.
- Reset mid-operation: all state returns to reset values immediately; a pending transfer is dropped (chart_ready goes high again in S_FILL).

Optional Feature:
UNDERRUN_COUNT_EN
- Defined:
  - Adds output underrun_count [7:0], reset 0.
  - Increments once per row per underrun event and saturates at 255.
  - Two rows underrunning on the same tick add 2.
- Undefined: the port and counter are absent; only the sticky underrun flag exists.

Test Plan:
- Reset, then release with chart_valid=0 -> positions 0/160/320/480, all notes 0, chart_ready=1, no motion across 3 vsync pulses.
- Feed patterns 4'b1001, 4'b0010, 4'b0100, 4'b0011 with run=1 -> notes1..4 hold those values, chart_ready=0, state S_RUN.
- One vsync pulse -> frame_tick is high for exactly one cycle; positions become 3/163/323/483.
- Advance until beat_pos4=639, then one more tick -> beat_pos4=0, notes4=0, chart_ready=1. Supplying 4'b1111 sets notes4=4'b1111 and chart_ready=0.
- Wrap row 4 with chart_valid=0, then one more tick -> underrun=1, pending cleared, notes4 remains 0. With UNDERRUN_COUNT_EN: underrun_count=1.
- run=0 for 5 vsync pulses -> positions unchanged and a refill still completes. Then run=1 -> the next tick advances positions by 3.
